// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path types: stored beat layout, write FSM states,
// statistics counter width and a saturating increment helper.
package eth_pkg;

  localparam int ETH_CNT_W = 16;

  // One stored byte with its end-of-frame marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } eth_beat_t;

  // Receive-side write FSM: accepting bytes, or discarding the rest of a frame.
  typedef enum logic [0:0] {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } eth_rx_wr_state_e;

  // Counter increment that holds at all-ones.
  function automatic logic [ETH_CNT_W-1:0] eth_sat_inc(input logic [ETH_CNT_W-1:0] v);
    return (v == {ETH_CNT_W{1'b1}}) ? v : v + ETH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output (one cycle latency). No reset on the array so it maps to block RAM.
module eth_sdp_ram #(
  parameter int WIDTH  = 9,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame buffer. Bytes from the MAC are written
// speculatively behind commit_ptr; a good tlast publishes the frame, a bad
// FCS or lack of space rolls wr_ptr back so the frame vanishes whole.
// Committed bytes are replayed through a 2-entry skid onto AXI-stream.
module eth_rx_frame_fifo
  import eth_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [ADDR_W-1:0]    fill_level,
  output logic [ETH_CNT_W-1:0] frame_ok_cnt,
  output logic [ETH_CNT_W-1:0] frame_drop_cnt,
  output logic                 overflow
);

  logic [ADDR_W-1:0]    wr_ptr_reg;
  logic [ADDR_W-1:0]    commit_ptr_reg;
  logic [ADDR_W-1:0]    rd_ptr_reg;
  eth_rx_wr_state_e     state_reg;
  logic [ETH_CNT_W-1:0] ok_cnt_reg;
  logic [ETH_CNT_W-1:0] drop_cnt_reg;
  logic                 overflow_reg;

  eth_beat_t            skid0_reg;
  eth_beat_t            skid1_reg;
  logic [1:0]           skid_cnt_reg;
  logic                 rd_pend_reg;

  logic                 full;
  logic                 ram_wr_en;
  eth_beat_t            ram_wr_beat;
  logic [8:0]           ram_rd_data;
  eth_beat_t            ram_rd_beat;
  logic                 pop;
  logic [1:0]           skid_use;
  logic                 rd_issue;

  // One slot stays empty so wr_ptr == rd_ptr unambiguously means empty.
  assign full = ((wr_ptr_reg + ADDR_W'(1)) == rd_ptr_reg);

  assign ram_wr_en   = s_axis_tvalid && (state_reg == WR_ACCEPT) && !full &&
                       !(s_axis_tlast && s_axis_tuser);
  assign ram_wr_beat = '{last: s_axis_tlast, data: s_axis_tdata};
  assign ram_rd_beat = ram_rd_data;

  // Skid occupancy counting the read in flight and crediting this cycle's pop,
  // which keeps a full-rate stream with only two skid entries.
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign skid_use = skid_cnt_reg + {1'b0, rd_pend_reg} - {1'b0, pop};
  assign rd_issue = (commit_ptr_reg != rd_ptr_reg) && (skid_use < 2'd2);

  eth_sdp_ram #(
    .WIDTH  (9),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (ram_wr_beat),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_rd_data)
  );

  // Write FSM: speculative writes, commit on good tlast, rollback on bad/full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      state_reg      <= WR_ACCEPT;
      ok_cnt_reg     <= '0;
      drop_cnt_reg   <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      overflow_reg <= 1'b0;
      if (s_axis_tvalid) begin
        case (state_reg)
          WR_ACCEPT: begin
            if (full) begin
              wr_ptr_reg   <= commit_ptr_reg;
              overflow_reg <= 1'b1;
              if (s_axis_tlast) drop_cnt_reg <= eth_sat_inc(drop_cnt_reg);
              else              state_reg    <= WR_DROP;
            end else if (s_axis_tlast && s_axis_tuser) begin
              wr_ptr_reg   <= commit_ptr_reg;
              drop_cnt_reg <= eth_sat_inc(drop_cnt_reg);
            end else begin
              wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
              if (s_axis_tlast) begin
                commit_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
                ok_cnt_reg     <= eth_sat_inc(ok_cnt_reg);
              end
            end
          end
          WR_DROP: begin
            if (s_axis_tlast) begin
              drop_cnt_reg <= eth_sat_inc(drop_cnt_reg);
              state_reg    <= WR_ACCEPT;
            end
          end
          default: state_reg <= WR_ACCEPT;
        endcase
      end
    end
  end

  // Read side: issue RAM reads into the skid and shift the skid on each pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      rd_pend_reg  <= 1'b0;
      skid_cnt_reg <= '0;
      skid0_reg    <= '0;
      skid1_reg    <= '0;
    end else begin
      if (rd_issue) rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      rd_pend_reg  <= rd_issue;
      skid_cnt_reg <= skid_cnt_reg + {1'b0, rd_pend_reg} - {1'b0, pop};
      if (pop) begin
        if (skid_cnt_reg == 2'd2) begin
          skid0_reg <= skid1_reg;
          if (rd_pend_reg) skid1_reg <= ram_rd_beat;
        end else if (rd_pend_reg) begin
          skid0_reg <= ram_rd_beat;
        end
      end else if (rd_pend_reg) begin
        if (skid_cnt_reg == 2'd0) skid0_reg <= ram_rd_beat;
        else                      skid1_reg <= ram_rd_beat;
      end
    end
  end

  assign m_axis_tvalid  = (skid_cnt_reg != 2'd0);
  assign m_axis_tdata   = skid0_reg.data;
  assign m_axis_tlast   = skid0_reg.last;
  assign fill_level     = wr_ptr_reg - rd_ptr_reg;
  assign frame_ok_cnt   = ok_cnt_reg;
  assign frame_drop_cnt = drop_cnt_reg;
  assign overflow       = overflow_reg;

endmodule
